flex_down_counter: RTL and testbench

// - Parameterized reloading down-counter; counterpart to the up-counting flex counter.
// - Loads a programmable start value, decrements on each enabled cycle and flags the terminal count (1).
// - Auto-reloads at terminal count. Serves as the period timer / sample-window generator for datapath blocks.

---
 rtl/flex_down_counter.sv | 70 +++++++
 tb/tb_flex_down_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/flex_down_counter.sv
// Reloading down-counter with a registered terminal-count flag (high while count == 1).
// Optional one-shot mode (no reload at terminal) is enabled by defining FLEX_DCNT_ONESHOT_EN.
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] reload_val,
`ifdef FLEX_DCNT_ONESHOT_EN
    input  logic                    oneshot,
`endif
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    terminal_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] CNT_TWO = NUM_CNT_BITS'(2);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;
    logic                    oneshot_act;

`ifdef FLEX_DCNT_ONESHOT_EN
    assign oneshot_act = oneshot;
`else
    assign oneshot_act = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        if (clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end else if (load) begin
            count_d = reload_val;
            flag_d  = (reload_val == CNT_ONE);
        end else if (count_enable) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
                flag_d  = (count_q == CNT_TWO);
            end else if (oneshot_act) begin
                // Terminal or idle in one-shot mode: park at idle, no restart.
                count_d = '0;
                flag_d  = 1'b0;
            end else begin
                // Start from idle or reload at terminal; reload_val of 0 keeps it idle.
                count_d = reload_val;
                flag_d  = (reload_val == CNT_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign terminal_flag = flag_q;

endmodule

// File: tb/tb_flex_down_counter.sv
// Self-checking bench for flex_down_counter: directed scenarios plus random traffic
// compared against an integer reference model of the counting rules.
module tb_flex_down_counter;

    localparam int W = 4;

`ifdef FLEX_DCNT_ONESHOT_EN
    localparam bit HAS_OS = 1'b1;
`else
    localparam bit HAS_OS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_rst;
    logic         clear, load, count_enable;
    logic [W-1:0] reload_val;
    logic         oneshot;
    logic [W-1:0] count_out;
    logic         terminal_flag;

    int n_assert = 0;
    int n_fail   = 0;
    int m_cnt    = 0;   // reference count value
    int flag_hits;

    always #5 clk = ~clk;

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .count_enable (count_enable),
        .reload_val   (reload_val),
`ifdef FLEX_DCNT_ONESHOT_EN
        .oneshot      (oneshot),
`endif
        .count_out    (count_out),
        .terminal_flag(terminal_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the reference model, then compare both outputs.
    task automatic cycle(input string tag, input logic c, input logic l, input logic e,
                         input int v, input logic o);
        clear        = c;
        load         = l;
        count_enable = e;
        reload_val   = W'(v);
        oneshot      = o;
        @(posedge clk);
        if (c)
            m_cnt = 0;
        else if (l)
            m_cnt = v;
        else if (e) begin
            if (m_cnt > 1)
                m_cnt = m_cnt - 1;
            else if (o && HAS_OS)
                m_cnt = 0;
            else
                m_cnt = v;
        end
        #1;
        check({tag, "_count"}, 32'(count_out), 32'(m_cnt));
        check({tag, "_flag"}, 32'(terminal_flag), 32'(m_cnt == 1));
    endtask

    initial begin
        n_rst = 1'b0; clear = 0; load = 0; count_enable = 0; reload_val = '0; oneshot = 0;
        #2;
        check("por_count", 32'(count_out), 32'd0);
        check("por_flag", 32'(terminal_flag), 32'd0);
        #10 n_rst = 1'b1;

        // Async reset mid-count at 5.
        cycle("rst_load", 0, 1, 0, 7, 0);
        cycle("rst_dec", 0, 0, 1, 7, 0);
        cycle("rst_dec", 0, 0, 1, 7, 0);
        check("rst_pre5", 32'(count_out), 32'd5);
        #2 n_rst = 1'b0;
        #1;
        m_cnt = 0;
        check("rst_async_count", 32'(count_out), 32'd0);
        check("rst_async_flag", 32'(terminal_flag), 32'd0);
        #3 n_rst = 1'b1;
        @(negedge clk);
        cycle("rst_start", 0, 0, 1, 6, 0);
        check("rst_start_val", 32'(count_out), 32'd6);

        // Continuous count from idle with reload 4.
        cycle("cont_clr", 1, 0, 0, 4, 0);
        for (int i = 0; i < 10; i++) begin
            cycle("cont", 0, 0, 1, 4, 0);
            check("cont_seq", 32'(count_out), 32'(4 - (i % 4)));
        end

        // Clear beats load at count 3.
        cycle("clr_ld", 0, 1, 0, 5, 0);
        cycle("clr_dec", 0, 0, 1, 5, 0);
        cycle("clr_dec", 0, 0, 1, 5, 0);
        cycle("clr_both", 1, 1, 1, 7, 0);
        check("clr_val", 32'(count_out), 32'd0);

        // Load overrides enable at count 2.
        cycle("lve_ld", 0, 1, 0, 3, 0);
        cycle("lve_dec", 0, 0, 1, 3, 0);
        cycle("lve_both", 0, 1, 1, 9, 0);
        check("lve_val", 32'(count_out), 32'd9);

        // Enable dropped at 2 holds for 3 cycles.
        cycle("hold_ld", 0, 1, 0, 4, 0);
        cycle("hold_dec", 0, 0, 1, 4, 0);
        cycle("hold_dec", 0, 0, 1, 4, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("hold", 0, 0, 0, 11, 0);
            check("hold_val", 32'(count_out), 32'd2);
        end

        // reload_val 0 never starts; reload_val 1 stays at terminal.
        cycle("zero_clr", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("zero", 0, 0, 1, 0, 0);
        cycle("zero_ld", 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("one", 0, 0, 1, 1, 0);
            check("one_flag", 32'(terminal_flag), 32'd1);
        end

        // Mid-count reload_val change applies only at the next reload; period is N.
        cycle("per_clr", 1, 0, 0, 5, 0);
        flag_hits = 0;
        for (int i = 0; i < 15; i++) begin
            cycle("per", 0, 0, 1, (i == 2) ? 12 : 5, 0);
            if (terminal_flag) flag_hits++;
        end
        check("period_hits", 32'(flag_hits), 32'd3);

`ifdef FLEX_DCNT_ONESHOT_EN
        cycle("os_ld", 0, 1, 0, 3, 1);
        check("os_3", 32'(count_out), 32'd3);
        cycle("os", 0, 0, 1, 3, 1); check("os_2", 32'(count_out), 32'd2);
        cycle("os", 0, 0, 1, 3, 1); check("os_1", 32'(count_out), 32'd1);
        cycle("os", 0, 0, 1, 3, 1); check("os_0", 32'(count_out), 32'd0);
        cycle("os", 0, 0, 1, 3, 1); check("os_idle", 32'(count_out), 32'd0);
        cycle("os_reld", 0, 1, 0, 3, 1); check("os_reload", 32'(count_out), 32'd3);
        cycle("os_clr", 1, 0, 0, 3, 1);
        cycle("os_start", 0, 0, 1, 6, 0); check("os_start", 32'(count_out), 32'd6);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic c, l, e, o;
            int v;
            c = ($urandom_range(15) == 0);
            l = ($urandom_range(7) == 0);
            e = ($urandom_range(3) != 0);
            v = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : int'($urandom_range(15));
            o = HAS_OS ? logic'($urandom_range(3) == 0) : 1'b0;
            cycle("rand", c, l, e, v, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
